// File: rtl/rom_arb_defs.sv
// rtl/rom_arb_defs.sv - shared state encodings, port indices and winner select for the ROM arbiter
package rom_arb_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_COPY = 1'b1;

  // On a tie, fixed mode always favours the CPU; otherwise the port not served last wins.
  function automatic logic pick_winner(input logic r0, input logic r1,
                                       input logic fixed_prio, input logic last);
    if (r0 && r1) begin
      return fixed_prio ? PORT_CPU : ~last;
    end else if (r0) begin
      return PORT_CPU;
    end else begin
      return PORT_COPY;
    end
  endfunction

endpackage

// File: rtl/rom_access_arbiter.sv
// rtl/rom_access_arbiter.sv - two-port read arbiter in front of the single-port boot/monitor ROM
// The ROM instance sits outside; its OUTPUT_REG setting must follow ROM_LATENCY (1 = off, 2 = on).
module rom_access_arbiter
  import rom_arb_defs::*;
#(
  parameter int ADDR_WIDTH     = 14,
  parameter int DATA_WIDTH     = 8,
  parameter int ROM_LATENCY    = 1,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  busy
);

  generate
    if (ROM_LATENCY < 1 || ROM_LATENCY > 4) begin : g_bad_latency
      $error("rom_access_arbiter: ROM_LATENCY must be in 1..4");
    end
  endgenerate

  localparam logic [2:0] LAT_CNT = 3'(ROM_LATENCY);
  localparam logic       FIXED   = (FIXED_PRIORITY != 0);

  arb_state_e            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] rom_address_q, rom_address_d;
  logic                  ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                  busy_q, busy_d;
  logic                  winner;

  assign winner = pick_winner(req0, req1, FIXED, last_grant_q);

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    rom_address_d = rom_address_q;
    ack0_d        = 1'b0;
    ack1_d        = 1'b0;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          rom_address_d = winner ? addr1 : addr0;
          owner_d       = winner;
          last_grant_d  = winner;
          cnt_d         = LAT_CNT;
          state_d       = ST_READ;
        end
      end
      ST_READ: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          if (owner_q == PORT_COPY) begin
            rdata1_d = rom_data;
            ack1_d   = 1'b1;
          end else begin
            rdata0_d = rom_data;
            ack0_d   = 1'b1;
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      owner_q       <= PORT_CPU;
      last_grant_q  <= PORT_COPY;
      cnt_q         <= 3'd0;
      rom_address_q <= '0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      rom_address_q <= rom_address_d;
      ack0_q        <= ack0_d;
      ack1_q        <= ack1_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
      busy_q        <= busy_d;
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign rom_address = rom_address_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_rom_access_arbiter.sv
// tb/tb_rom_access_arbiter.sv - scoreboard bench for rom_access_arbiter across latency/priority variants
module tb_rom_access_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rom_fn(input logic [13:0] a);
    if (a == 14'h0000) return 8'hC3;
    if (a == 14'h3FFF) return 8'h5A;
    return a[7:0] ^ {a[13:8], 2'b00} ^ 8'h96;
  endfunction

  // a: L=1 round robin, b: L=2 round robin, c: L=1 fixed priority
  logic        req0_a = 0, req1_a = 0, req0_b = 0, req1_b = 0, req0_c = 0, req1_c = 0;
  logic [13:0] addr0_a = 0, addr1_a = 0, addr0_b = 0, addr1_b = 0, addr0_c = 0, addr1_c = 0;
  logic        ack0_a, ack1_a, ack0_b, ack1_b, ack0_c, ack1_c;
  logic        busy_a, busy_b, busy_c;
  logic [7:0]  rdata0_a, rdata1_a, rdata0_b, rdata1_b, rdata0_c, rdata1_c;
  logic [13:0] ra_a, ra_b, ra_c;
  logic [7:0]  rd_a, rd_b, rd_c;

  assign rd_a = rom_fn(ra_a);
  assign rd_c = rom_fn(ra_c);
  always @(posedge clk) rd_b <= rom_fn(ra_b);

  rom_access_arbiter #(.ADDR_WIDTH(14), .DATA_WIDTH(8), .ROM_LATENCY(1), .FIXED_PRIORITY(0)) u_a (
    .clock(clk), .reset_n(reset_n), .req0(req0_a), .addr0(addr0_a), .ack0(ack0_a), .rdata0(rdata0_a),
    .req1(req1_a), .addr1(addr1_a), .ack1(ack1_a), .rdata1(rdata1_a),
    .rom_address(ra_a), .rom_data(rd_a), .busy(busy_a));
  rom_access_arbiter #(.ADDR_WIDTH(14), .DATA_WIDTH(8), .ROM_LATENCY(2), .FIXED_PRIORITY(0)) u_b (
    .clock(clk), .reset_n(reset_n), .req0(req0_b), .addr0(addr0_b), .ack0(ack0_b), .rdata0(rdata0_b),
    .req1(req1_b), .addr1(addr1_b), .ack1(ack1_b), .rdata1(rdata1_b),
    .rom_address(ra_b), .rom_data(rd_b), .busy(busy_b));
  rom_access_arbiter #(.ADDR_WIDTH(14), .DATA_WIDTH(8), .ROM_LATENCY(1), .FIXED_PRIORITY(1)) u_c (
    .clock(clk), .reset_n(reset_n), .req0(req0_c), .addr0(addr0_c), .ack0(ack0_c), .rdata0(rdata0_c),
    .req1(req1_c), .addr1(addr1_c), .ack1(ack1_c), .rdata1(rdata1_c),
    .rom_address(ra_c), .rom_data(rd_c), .busy(busy_c));

  typedef struct {
    logic       port;
    logic [7:0] data;
    int         edge_n;
  } exp_t;

  exp_t       q_a[$], q_b[$], q_c[$];
  logic [7:0] sh [0:2][0:1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int inst, input logic port, input logic [13:0] addr, input int edge_n);
    exp_t e;
    e.port = port;
    e.data = rom_fn(addr);
    e.edge_n = edge_n;
    case (inst)
      0: q_a.push_back(e);
      1: q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  task automatic mon(input int inst, input logic a0, input logic a1,
                     input logic [7:0] d0, input logic [7:0] d1);
    exp_t e;
    int   sz;
    if (a0 && a1) begin
      total++;
      bad++;
      $display("FAIL both_ack inst=%0d: got ack0=1 ack1=1 expected at most one", inst);
      return;
    end
    if (!(a0 || a1)) return;
    case (inst)
      0: sz = q_a.size();
      1: sz = q_b.size();
      default: sz = q_c.size();
    endcase
    if (sz == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_ack inst=%0d edge=%0d: got ack0=%0b ack1=%0b expected none", inst, cyc, a0, a1);
      return;
    end
    case (inst)
      0: e = q_a.pop_front();
      1: e = q_b.pop_front();
      default: e = q_c.pop_front();
    endcase
    chk($sformatf("ack_port inst=%0d", inst), 32'(a1), 32'(e.port));
    chk($sformatf("ack_edge inst=%0d", inst), 32'(cyc), 32'(e.edge_n));
    chk($sformatf("rdata inst=%0d", inst), 32'(a1 ? d1 : d0), 32'(e.data));
    chk($sformatf("other_rdata inst=%0d", inst), 32'(a1 ? d0 : d1), 32'(sh[inst][!a1]));
    sh[inst][e.port] = e.data;
  endtask

  always @(posedge clk) begin
    #1;
    mon(0, ack0_a, ack1_a, rdata0_a, rdata1_a);
    mon(1, ack0_b, ack1_b, rdata0_b, rdata1_b);
    mon(2, ack0_c, ack1_c, rdata0_c, rdata1_c);
  end

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_rst(input string nm, input logic a0, input logic a1, input logic [7:0] d0,
                         input logic [7:0] d1, input logic [13:0] ra, input logic b);
    chk({nm, "_ack"}, 32'({a0, a1}), 32'd0);
    chk({nm, "_rdata"}, 32'({d0, d1}), 32'd0);
    chk({nm, "_rom_address"}, 32'(ra), 32'd0);
    chk({nm, "_busy"}, 32'(b), 32'd0);
  endtask

  task automatic clear_shadow();
    for (int i = 0; i < 3; i++) begin
      sh[i][0] = 8'h00;
      sh[i][1] = 8'h00;
    end
  endtask

  initial begin
    int c;
    clear_shadow();
    nclk(2);
    chk_rst("reset_a", ack0_a, ack1_a, rdata0_a, rdata1_a, ra_a, busy_a);
    chk_rst("reset_b", ack0_b, ack1_b, rdata0_b, rdata1_b, ra_b, busy_b);
    chk_rst("reset_c", ack0_c, ack1_c, rdata0_c, rdata1_c, ra_c, busy_c);
    reset_n = 1'b1;
    nclk(2);

    // single read on port 0, latency 1
    c = cyc;
    addr0_a = 14'h0000;
    req0_a = 1'b1;
    push(0, 1'b0, 14'h0000, c + 2);
    nclk(1);
    chk("t1_rom_address", 32'(ra_a), 32'h0);
    chk("t1_busy", 32'(busy_a), 32'd1);
    nclk(1);
    req0_a = 1'b0;
    nclk(3);
    chk("t1_idle_busy", 32'(busy_a), 32'd0);

    // address change and early drop right after grant
    c = cyc;
    addr0_a = 14'h0200;
    req0_a = 1'b1;
    push(0, 1'b0, 14'h0200, c + 2);
    nclk(1);
    addr0_a = 14'h0300;
    req0_a = 1'b0;
    chk("t4_latched_addr", 32'(ra_a), 32'h0200);
    nclk(4);
    chk("t4_busy", 32'(busy_a), 32'd0);
    chk("t4_addr_hold", 32'(ra_a), 32'h0200);

    // latency 2: port 0 first so rdata0 carries a value, then port 1 at the top address
    c = cyc;
    addr0_b = 14'h0010;
    req0_b = 1'b1;
    push(1, 1'b0, 14'h0010, c + 3);
    nclk(3);
    req0_b = 1'b0;
    nclk(2);
    c = cyc;
    addr1_b = 14'h3FFF;
    req1_b = 1'b1;
    push(1, 1'b1, 14'h3FFF, c + 3);
    nclk(3);
    req1_b = 1'b0;
    nclk(2);
    chk("t3_rdata1", 32'(rdata1_b), 32'h5A);
    chk("t3_rdata0_held", 32'(rdata0_b), 32'(rom_fn(14'h0010)));

    // reset in the middle of a read
    addr0_a = 14'h0055;
    req0_a = 1'b1;
    nclk(1);
    req0_a = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_rst("t5_a", ack0_a, ack1_a, rdata0_a, rdata1_a, ra_a, busy_a);
    clear_shadow();
    nclk(2);
    reset_n = 1'b1;
    nclk(1);
    c = cyc;
    addr1_a = 14'h0777;
    req1_a = 1'b1;
    push(0, 1'b1, 14'h0777, c + 2);
    nclk(2);
    req1_a = 1'b0;
    nclk(3);

    // round-robin tie with both ports held high
    c = cyc;
    addr0_a = 14'h0123;
    addr1_a = 14'h0456;
    req0_a = 1'b1;
    req1_a = 1'b1;
    push(0, 1'b0, 14'h0123, c + 2);
    push(0, 1'b1, 14'h0456, c + 5);
    push(0, 1'b0, 14'h0123, c + 8);
    push(0, 1'b1, 14'h0456, c + 11);
    nclk(11);
    req0_a = 1'b0;
    req1_a = 1'b0;
    nclk(3);

    // fixed priority: port 0 starves port 1 until it lets go
    c = cyc;
    addr0_c = 14'h0011;
    addr1_c = 14'h0022;
    req0_c = 1'b1;
    req1_c = 1'b1;
    push(2, 1'b0, 14'h0011, c + 2);
    push(2, 1'b0, 14'h0011, c + 5);
    push(2, 1'b0, 14'h0011, c + 8);
    push(2, 1'b1, 14'h0022, c + 11);
    nclk(8);
    req0_c = 1'b0;
    nclk(3);
    req1_c = 1'b0;
    nclk(5);

    chk("q_a_drained", 32'(q_a.size()), 32'd0);
    chk("q_b_drained", 32'(q_b.size()), 32'd0);
    chk("q_c_drained", 32'(q_c.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
